fifo_burst_reader: RTL and testbench
====================================

// Module: fifo_burst_reader
// PURPOSE
//  Read-side controller for the 64-deep dual-clock FIFO; runs entirely in the rd_clk domain.
//  Drains a commanded burst of N words and presents them downstream on a valid/ready stream.
//  Each word carries an incrementing destination address, so results land in SRAM sequentially.
//  Sits between the FIFO read port (rd/o_empty/out) and the SRAM write path or next-stage consumer.
// PARAMETERS
//  bw      4   bits per lane; must match the FIFO
//  simd    1   lanes per word; data width is simd*bw
//  len_w   7   burst length width; max burst is 2**len_w-1
//  addr_w  11  destination address width; the address wraps modulo 2**addr_w
// PORTS
//  rd_clk      in   1          read-domain clock
//  reset       in   1          synchronous reset, active-high
//  start       in   1          burst command strobe; sampled only in IDLE
//  burst_len   in   len_w      number of words to pop, sampled with start
//  base_addr   in   addr_w     address of the first word, sampled with start
//  busy        out  1          high whenever state is not IDLE
//  done        out  1          one-cycle pulse when the burst completes
//  fifo_rd     out  1          pop strobe to the FIFO rd input
//  fifo_empty  in   1          FIFO o_empty
//  fifo_out    in   simd*bw    FIFO head data; combinational on rd_ptr
//  m_valid     out  1          output word valid
//  m_ready     in   1          downstream accepts the word
//  m_data      out  simd*bw    output word
//  m_addr      out  addr_w     destination address of m_data
// BEHAVIOUR
//  - Reset (synchronous, active-high, clock rd_clk): state IDLE; busy=0, done=0, fifo_rd=0,
//    m_valid=0, m_data=0, m_addr=0, remaining=0. Reset mid-burst abandons the burst without
//    asserting done. FIFO contents are not touched.
//  - States and transitions:
//      IDLE  -> BURST on start && burst_len!=0
//      IDLE  -> DONE  on start && burst_len==0
//      BURST -> DRAIN when the last pop is issued (remaining becomes 0)
//      DRAIN -> DONE  when the output register empties (m_valid && m_ready, or m_valid==0)
//      DONE  -> IDLE  after one cycle; done=1 only while in DONE
//  - start outside IDLE is ignored. burst_len and base_addr are latched on the accepting edge.
//  - Pop rule: fifo_rd = (state==BURST) && !fifo_empty && (!m_valid || m_ready). It is
//    combinational, so fifo_rd is never asserted while fifo_empty=1.
//  - On a pop edge: m_data<=fifo_out, m_addr<=addr_cnt, m_valid<=1, addr_cnt++ (wraps), remaining--.
//    Latency is 1 rd_clk from the pop to m_valid. Full throughput of 1 word/cycle with m_ready=1.
//  - Simultaneous accept and pop in the same cycle: the register reloads and m_valid stays 1.
//    Accept without a pop: m_valid<=0.
//  - m_data and m_addr hold stable while m_valid && !m_ready.
//  - FIFO empty during BURST: the block stalls with no pop. It never times out.
//  - Address wrap: base_addr=2**addr_w-1 gives the sequence max, 0, 1, ...
// CONFIGURATION
//  Macro FIFO_BURST_READER_STATS_EN.
//  - Defined: adds output stall_cycles [15:0]. It counts cycles in BURST with fifo_empty=1,
//    saturates at 16'hFFFF, clears on an accepted start, and resets to 0.
//  - Undefined: the port and the counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Package fifo_burst_pkg: state encoding constants (IDLE=2'd0, BURST=2'd1, DRAIN=2'd2,
//    DONE=2'd3) and default widths FBR_LEN_W=7, FBR_ADDR_W=11.
//  - Sub-module fifo_out_stage: a one-entry valid/ready output register (data+addr) with a
//    load/accept interface.
//  - The top level holds the FSM, the remaining counter, the address counter and the optional
//    stats counter.
// TESTING
//  1. FIFO preloaded with 8 words 0x1..0x8, start, len=8, base=0x10, m_ready=1 ->
//     8 beats on consecutive cycles, data 1..8, addr 0x10..0x17; done pulses once; fifo_rd count is 8.
//  2. Same burst with m_ready toggling 1,0,1,0 -> data and addr hold during stalls,
//     no words lost or duplicated, fifo_rd never asserted while m_valid && !m_ready.
//  3. FIFO empty, start len=3, then one write every 5 cycles -> 3 beats; with the macro
//     defined, stall_cycles >= 8; fifo_rd never asserted with fifo_empty=1.
//  4. start with len=0 -> done the next cycle after DONE entry, with no fifo_rd and no m_valid.
//     start asserted while busy -> ignored.
//  5. base=0x7FE, len=4 -> addr sequence 0x7FE, 0x7FF, 0x000, 0x001.
//  6. reset asserted mid-burst after 2 of 6 beats -> next cycle busy=0, m_valid=0, no done pulse;
//     a new burst then runs correctly.

Source files
------------

// File: rtl/fifo_burst_pkg.sv
// rtl/fifo_burst_pkg.sv - FSM state encoding and default widths for the FIFO burst reader
package fifo_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fbr_state_e;

    localparam int FBR_LEN_W  = 7;
    localparam int FBR_ADDR_W = 11;

endpackage

// File: rtl/fifo_out_stage.sv
// rtl/fifo_out_stage.sv - one-entry valid/ready output register holding a data word and its address
module fifo_out_stage
    import fifo_burst_pkg::*;
#(
    parameter int data_w = 4,
    parameter int addr_w = FBR_ADDR_W
) (
    input  logic              rd_clk,
    input  logic              reset,
    input  logic              load,
    input  logic [data_w-1:0] load_data,
    input  logic [addr_w-1:0] load_addr,
    output logic              can_load,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [data_w-1:0] m_data,
    output logic [addr_w-1:0] m_addr
);

    // The register can take a new word when empty or when its current word leaves this cycle.
    assign can_load = !m_valid || m_ready;

    // Load has priority so an accept and a pop in the same cycle keep m_valid high.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_addr  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_addr  <= load_addr;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains a commanded burst from the FIFO onto an addressed valid/ready stream; optional FIFO_BURST_READER_STATS_EN adds stall_cycles
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int bw     = 4,
    parameter int simd   = 1,
    parameter int len_w  = FBR_LEN_W,
    parameter int addr_w = FBR_ADDR_W
) (
    input  logic                 rd_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [len_w-1:0]     burst_len,
    input  logic [addr_w-1:0]    base_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 fifo_rd,
    input  logic                 fifo_empty,
    input  logic [simd*bw-1:0]   fifo_out,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [simd*bw-1:0]   m_data,
`ifdef FIFO_BURST_READER_STATS_EN
    output logic [15:0]          stall_cycles,
`endif
    output logic [addr_w-1:0]    m_addr
);

    localparam logic [len_w-1:0]  LEN_ONE  = {{(len_w-1){1'b0}}, 1'b1};
    localparam logic [addr_w-1:0] ADDR_ONE = {{(addr_w-1){1'b0}}, 1'b1};

    fbr_state_e        state;
    fbr_state_e        state_nxt;
    logic [len_w-1:0]  remaining;
    logic [addr_w-1:0] addr_cnt;
    logic              stage_can_load;
    logic              accept_start;

    assign accept_start = (state == IDLE) && start;

    // Pops only when the FIFO has data and the output register has room for it.
    assign fifo_rd = (state == BURST) && !fifo_empty && stage_can_load;

    fifo_out_stage #(
        .data_w (simd*bw),
        .addr_w (addr_w)
    ) u_out_stage (
        .rd_clk    (rd_clk),
        .reset     (reset),
        .load      (fifo_rd),
        .load_data (fifo_out),
        .load_addr (addr_cnt),
        .can_load  (stage_can_load),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_addr    (m_addr)
    );

    // State register.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs; a zero-length burst goes straight to DONE.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (burst_len != '0) ? BURST : DONE;
                end
            end
            BURST: begin
                if (fifo_rd && (remaining == LEN_ONE)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!m_valid || m_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Burst bookkeeping: latch the command on accept, then count down and step the address per pop.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            remaining <= '0;
            addr_cnt  <= '0;
        end else if (accept_start) begin
            remaining <= burst_len;
            addr_cnt  <= base_addr;
        end else if (fifo_rd) begin
            remaining <= remaining - LEN_ONE;
            addr_cnt  <= addr_cnt + ADDR_ONE;
        end
    end

`ifdef FIFO_BURST_READER_STATS_EN
    // Saturating count of BURST cycles spent waiting on an empty FIFO.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (accept_start) begin
            stall_cycles <= '0;
        end else if ((state == BURST) && fifo_empty && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

    localparam int BW     = 4;
    localparam int SIMD   = 1;
    localparam int LEN_W  = 7;
    localparam int ADDR_W = 11;
    localparam int DW     = BW*SIMD;

    logic              rd_clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  burst_len = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              busy;
    logic              done;
    logic              fifo_rd;
    logic              fifo_empty;
    logic [DW-1:0]     fifo_out;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [DW-1:0]     m_data;
    logic [ADDR_W-1:0] m_addr;
`ifdef FIFO_BURST_READER_STATS_EN
    logic [15:0]       stall_cycles;
`endif

    // FIFO model
    logic              wr_en = 1'b0;
    logic [DW-1:0]     wr_data = '0;
    logic              fifo_clr = 1'b0;
    logic [DW-1:0]     mem [64];
    logic [6:0]        wp = '0;
    logic [6:0]        rp = '0;

    fifo_burst_reader #(
        .bw     (BW),
        .simd   (SIMD),
        .len_w  (LEN_W),
        .addr_w (ADDR_W)
    ) dut (
        .rd_clk       (rd_clk),
        .reset        (reset),
        .start        (start),
        .burst_len    (burst_len),
        .base_addr    (base_addr),
        .busy         (busy),
        .done         (done),
        .fifo_rd      (fifo_rd),
        .fifo_empty   (fifo_empty),
        .fifo_out     (fifo_out),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
`ifdef FIFO_BURST_READER_STATS_EN
        .stall_cycles (stall_cycles),
`endif
        .m_addr       (m_addr)
    );

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) begin
        if (fifo_clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) begin
                mem[wp[5:0]] <= wr_data;
                wp <= wp + 7'd1;
            end
            if (fifo_rd) begin
                rp <= rp + 7'd1;
            end
        end
    end

    assign fifo_empty = (wp == rp);
    assign fifo_out   = mem[rp[5:0]];

    int checks = 0;
    int failures = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor, sampled on the falling edge
    int            cyc = 0;
    int            rd_cnt = 0;
    int            done_cnt = 0;
    int            viol = 0;
    int            mv_cnt = 0;
    logic [DW-1:0]     got_data [$];
    logic [ADDR_W-1:0] got_addr [$];
    int            beat_cyc [$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0]     prev_data = '0;
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(negedge rd_clk) begin
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (fifo_rd) rd_cnt++;
            if (fifo_rd && fifo_empty) viol++;
            if (fifo_rd && m_valid && !m_ready) viol++;
            if (done) done_cnt++;
            if (m_valid) mv_cnt++;
            if (prev_stall && (!m_valid || m_data != prev_data || m_addr != prev_addr)) viol++;
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_addr.push_back(m_addr);
                beat_cyc.push_back(cyc);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_addr  = m_addr;
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic fifo_load(input int n, input logic [DW-1:0] first);
        logic [DW-1:0] v;
        v = first;
        for (int k = 0; k < n; k++) begin
            wr_en = 1'b1;
            wr_data = v;
            v = v + 1'b1;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic fifo_flush();
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
    endtask

    task automatic start_burst(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] base);
        start = 1'b1;
        burst_len = len;
        base_addr = base;
        tick();
        start = 1'b0;
    endtask

    // mode 0: m_ready held high; mode 1: m_ready toggles 1,0,1,0
    task automatic wait_done(input int mode, input int feed_n, input logic [DW-1:0] feed_first,
                             input int feed_every, input int budget, output bit seen);
        logic [DW-1:0] fv;
        int left;
        fv = feed_first;
        left = feed_n;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            wr_en = (feed_every != 0) && (left > 0) && ((i % feed_every) == feed_every - 1);
            if (wr_en) begin
                wr_data = fv;
                fv = fv + 1'b1;
                left--;
            end
            m_ready = (mode == 0) ? 1'b1 : ((i % 2) == 0);
            @(negedge rd_clk);
            if (done) seen = 1'b1;
            @(posedge rd_clk);
            #1;
            wr_en = 1'b0;
            if (seen) break;
        end
        wr_en = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic check_beats(input string tag, input int ix, input int n,
                               input logic [DW-1:0] d0, input logic [ADDR_W-1:0] a0);
        logic [DW-1:0] d;
        logic [ADDR_W-1:0] a;
        d = d0;
        a = a0;
        expect_eq($sformatf("%s_count", tag), got_data.size() - ix, n);
        for (int k = 0; k < n; k++) begin
            if (ix + k < got_data.size()) begin
                expect_eq($sformatf("%s_data%0d", tag, k), got_data[ix+k], d);
                expect_eq($sformatf("%s_addr%0d", tag, k), got_addr[ix+k], a);
            end
            d = d + 1'b1;
            a = a + 1'b1;
        end
    endtask

    initial begin
        bit seen;
        int ix, r0, d0, v0, m0, n;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_done", done, 0);
        expect_eq("rst_fifo_rd", fifo_rd, 0);
        expect_eq("rst_m_valid", m_valid, 0);
        expect_eq("rst_m_data", m_data, 0);
        expect_eq("rst_m_addr", m_addr, 0);
        reset = 1'b0;
        tick();

        // 1: full-throughput burst of 8
        fifo_load(8, 4'h1);
        ix = got_data.size(); r0 = rd_cnt; d0 = done_cnt; v0 = viol;
        start_burst(7'd8, 11'h010);
        wait_done(0, 0, '0, 0, 100, seen);
        expect_eq("t1_done_seen", seen, 1);
        expect_eq("t1_done_pulses", done_cnt - d0, 1);
        expect_eq("t1_pops", rd_cnt - r0, 8);
        check_beats("t1", ix, 8, 4'h1, 11'h010);
        if (beat_cyc.size() >= ix + 8)
            expect_eq("t1_back_to_back", beat_cyc[ix+7] - beat_cyc[ix], 7);
        expect_eq("t1_viol", viol - v0, 0);
        expect_eq("t1_busy_after", busy, 0);

        // 2: same burst with backpressure
        fifo_load(8, 4'h1);
        ix = got_data.size(); r0 = rd_cnt; d0 = done_cnt; v0 = viol;
        start_burst(7'd8, 11'h010);
        wait_done(1, 0, '0, 0, 200, seen);
        expect_eq("t2_done_seen", seen, 1);
        expect_eq("t2_done_pulses", done_cnt - d0, 1);
        expect_eq("t2_pops", rd_cnt - r0, 8);
        check_beats("t2", ix, 8, 4'h1, 11'h010);
        expect_eq("t2_viol", viol - v0, 0);

        // 3: empty FIFO, trickle feed one word every 5 cycles
        ix = got_data.size(); r0 = rd_cnt; v0 = viol;
        start_burst(7'd3, 11'h100);
        wait_done(0, 3, 4'hA, 5, 200, seen);
        expect_eq("t3_done_seen", seen, 1);
        expect_eq("t3_pops", rd_cnt - r0, 3);
        check_beats("t3", ix, 3, 4'hA, 11'h100);
        expect_eq("t3_viol", viol - v0, 0);
`ifdef FIFO_BURST_READER_STATS_EN
        expect_eq("t3_stall_ge8", (stall_cycles >= 16'd8), 1);
`endif

        // 4a: zero-length burst
        r0 = rd_cnt; m0 = mv_cnt;
        start_burst(7'd0, 11'h055);
        expect_eq("t4_done_now", done, 1);
        expect_eq("t4_busy_now", busy, 1);
        tick();
        expect_eq("t4_done_after", done, 0);
        expect_eq("t4_busy_after", busy, 0);
        expect_eq("t4_pops", rd_cnt - r0, 0);
        expect_eq("t4_valids", mv_cnt - m0, 0);

        // 4b: start while busy is ignored
        ix = got_data.size(); r0 = rd_cnt; d0 = done_cnt;
        start_burst(7'd2, 11'h040);
        tick();
        start_burst(7'd5, 11'h300);
        wait_done(0, 2, 4'h3, 2, 100, seen);
        expect_eq("t4b_done_seen", seen, 1);
        tick();
        tick();
        expect_eq("t4b_busy_idle", busy, 0);
        expect_eq("t4b_pops", rd_cnt - r0, 2);
        expect_eq("t4b_done_pulses", done_cnt - d0, 1);
        check_beats("t4b", ix, 2, 4'h3, 11'h040);

        // 5: address wrap
        fifo_load(4, 4'h1);
        ix = got_data.size();
        start_burst(7'd4, 11'h7FE);
        wait_done(0, 0, '0, 0, 100, seen);
        expect_eq("t5_done_seen", seen, 1);
        check_beats("t5", ix, 4, 4'h1, 11'h7FE);

        // 6: reset mid-burst after 2 beats, then a fresh burst
        fifo_load(6, 4'h1);
        d0 = done_cnt;
        start_burst(7'd6, 11'h200);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge rd_clk);
            if (m_valid && m_ready) n++;
            @(posedge rd_clk);
            #1;
            if (n >= 2) break;
        end
        expect_eq("t6_two_beats", n, 2);
        reset = 1'b1;
        tick();
        expect_eq("t6_busy_rst", busy, 0);
        expect_eq("t6_m_valid_rst", m_valid, 0);
        expect_eq("t6_m_addr_rst", m_addr, 0);
        reset = 1'b0;
        tick();
        tick();
        expect_eq("t6_no_done", done_cnt - d0, 0);
        fifo_flush();
        fifo_load(3, 4'h5);
        ix = got_data.size();
        start_burst(7'd3, 11'h020);
        wait_done(0, 0, '0, 0, 100, seen);
        expect_eq("t6_done_seen", seen, 1);
        check_beats("t6", ix, 3, 4'h5, 11'h020);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
